// File: rtl/uart_io.sv
// uart_io: memory-mapped UART on the CPU I/O page with 4-deep TX/RX FIFOs,
// a programmable baud divisor, sticky error flags and one interrupt flag.
// Optional build macro UART_PARITY_EN switches framing from 8N1 to 8E1.
module uart_io #(
   parameter logic [7:0]  BASE_ADDR = 8'h20,
   parameter int          FIFO_AW   = 2,
   parameter logic [15:0] DIV_RESET = 16'd1665
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic [7:0] address,
   input  logic       w_en,
   input  logic       r_en,
   output logic [7:0] dout,
   input  logic       rx,
   output logic       tx,
   output logic       irq_flag,
   input  logic       irq_flag_clr
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam logic [7:0] OFF_DATA = 8'd0, OFF_STAT = 8'd1, OFF_CTRL = 8'd2,
                          OFF_DLO  = 8'd3, OFF_DHI  = 8'd4;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`ifdef UART_PARITY_EN
   localparam state_t POST_DATA = S_PAR;
`else
   localparam state_t POST_DATA = S_STOP;
`endif

   // Register interface; a write wins over a simultaneous read.
   logic [7:0]  off, rdata, dout_q, dout_d;
   logic        wr, rd;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  err_q, err_d, err_clr;   // {parity, framing, overrun}
   logic        irq_q, irq_d, irq_set, txe_prev_q;
   logic        perr_set, ferr_set, ovr_set;

   assign off     = address - BASE_ADDR;
   assign wr      = w_en;
   assign rd      = r_en & ~w_en;
   assign err_clr = (wr && off == OFF_STAT) ? din[6:4] : 3'b000;

   // TX FIFO
   logic [7:0]         txf_mem [DEPTH];
   logic [FIFO_AW-1:0] txf_wp_q, txf_rp_q;
   logic [CW-1:0]      txf_cnt_q;
   logic               txf_full, txf_empty, txf_push, txf_pop;
   logic [7:0]         txf_rdata;

   // RX FIFO
   logic [7:0]         rxf_mem [DEPTH];
   logic [FIFO_AW-1:0] rxf_wp_q, rxf_rp_q;
   logic [CW-1:0]      rxf_cnt_q;
   logic               rxf_full, rxf_empty, rxf_push, rxf_pop;

   // TX FSM
   state_t      tx_st_q, tx_st_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        tx_par_q, tx_par_d, tx_tick, tx_load, tx_busy, tx_empty;

   // RX FSM
   state_t      rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_perr_q, rx_perr_d, rx_tick, rx_push;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;

   assign txf_full  = (txf_cnt_q == CW'(DEPTH));
   assign txf_empty = (txf_cnt_q == '0);
   assign txf_rdata = txf_mem[txf_rp_q];
   assign txf_pop   = tx_load;
   assign txf_push  = wr && off == OFF_DATA && (!txf_full || txf_pop);

   assign rxf_full  = (rxf_cnt_q == CW'(DEPTH));
   assign rxf_empty = (rxf_cnt_q == '0);
   assign rxf_pop   = rd && off == OFF_DATA && !rxf_empty;
   assign rxf_push  = rx_push && (!rxf_full || rxf_pop);

   assign ovr_set   = rx_push && !rxf_push;
   assign perr_set  = rx_push && rx_perr_q;
   assign tx_busy   = (tx_st_q != S_IDLE);
   assign tx_empty  = txf_empty && !tx_busy;
   assign tx_tick   = (tx_cnt_q == '0);
   assign rx_tick   = (rx_cnt_q == '0);
   assign irq_set   = (ctrl_q[0] && rxf_push) || (ctrl_q[1] && tx_empty && !txe_prev_q);

   // FIFO storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (txf_push) txf_mem[txf_wp_q] <= din;
      if (rxf_push) rxf_mem[rxf_wp_q] <= rx_sh_q;
   end

   // FIFO pointers and occupancy counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txf_wp_q <= '0; txf_rp_q <= '0; txf_cnt_q <= '0;
         rxf_wp_q <= '0; rxf_rp_q <= '0; rxf_cnt_q <= '0;
      end else begin
         if (txf_push) txf_wp_q <= txf_wp_q + 1'b1;
         if (txf_pop)  txf_rp_q <= txf_rp_q + 1'b1;
         txf_cnt_q <= txf_cnt_q + CW'(txf_push) - CW'(txf_pop);
         if (rxf_push) rxf_wp_q <= rxf_wp_q + 1'b1;
         if (rxf_pop)  rxf_rp_q <= rxf_rp_q + 1'b1;
         rxf_cnt_q <= rxf_cnt_q + CW'(rxf_push) - CW'(rxf_pop);
      end
   end

   // Read mux for the registered read port
   always_comb begin
      rdata = 8'h00;
      case (off)
         OFF_DATA: rdata = rxf_empty ? 8'h00 : rxf_mem[rxf_rp_q];
         OFF_STAT: rdata = {1'b0, err_q, tx_busy, tx_empty, txf_full, !rxf_empty};
         OFF_CTRL: rdata = {6'b0, ctrl_q};
         OFF_DLO:  rdata = div_q[7:0];
         OFF_DHI:  rdata = div_q[15:8];
         default:  rdata = 8'h00;
      endcase
   end

   // Next state of control registers, sticky errors, read data and interrupt
   always_comb begin
      ctrl_d = ctrl_q;
      div_d  = div_q;
      if (wr) begin
         case (off)
            OFF_CTRL: ctrl_d = din[1:0];
            OFF_DLO:  div_d[7:0]  = din;
            OFF_DHI:  div_d[15:8] = din;
            default:  ;
         endcase
      end
      err_d  = (err_q & ~err_clr) | {perr_set, ferr_set, ovr_set};
      dout_d = rd ? rdata : dout_q;
      irq_d  = irq_set | (irq_q & ~irq_flag_clr);
   end

   // Control register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0; div_q <= DIV_RESET; err_q <= '0;
         dout_q <= '0; irq_q <= 1'b0; txe_prev_q <= 1'b1;
      end else begin
         ctrl_q <= ctrl_d; div_q <= div_d; err_q <= err_d;
         dout_q <= dout_d; irq_q <= irq_d; txe_prev_q <= tx_empty;
      end
   end

   assign dout     = dout_q;
   assign irq_flag = irq_q;

   // TX FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_div_q <= '0;
         tx_bit_q <= '0; tx_sh_q <= '0; tx_par_q <= 1'b0;
      end else begin
         tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
         tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d;
      end
   end

   // TX FSM next state; leaving STOP with data pending starts the next frame at once
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_tick ? tx_div_q : tx_cnt_q - 16'd1;
      tx_div_d = tx_div_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_par_d = tx_par_q;
      tx_load  = 1'b0;
      case (tx_st_q)
         S_IDLE: begin
            tx_cnt_d = tx_cnt_q;
            tx_load  = !txf_empty;
         end
         S_START: if (tx_tick) begin tx_st_d = S_DATA; tx_bit_d = 3'd0; end
         S_DATA: if (tx_tick) begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_st_d = POST_DATA;
         end
         S_PAR:  if (tx_tick) tx_st_d = S_STOP;
         S_STOP: if (tx_tick) begin tx_st_d = S_IDLE; tx_load = !txf_empty; end
         default: tx_st_d = S_IDLE;
      endcase
      // divisor is latched here so a mid-frame DIV write never disturbs a frame
      if (tx_load) begin
         tx_st_d  = S_START;
         tx_sh_d  = txf_rdata;
         tx_par_d = ^txf_rdata;
         tx_div_d = div_q;
         tx_cnt_d = div_q;
      end
   end

   // TX line output decoded from FSM state
   always_comb begin
      case (tx_st_q)
         S_START: tx = 1'b0;
         S_DATA:  tx = tx_sh_q[0];
         S_PAR:   tx = tx_par_q;
         default: tx = 1'b1;
      endcase
   end

   // RX synchronizer, edge history and FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
         rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_div_q <= '0;
         rx_bit_q <= '0; rx_sh_q <= '0; rx_perr_q <= 1'b0;
      end else begin
         rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
         rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
         rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d; rx_perr_q <= rx_perr_d;
      end
   end

   // RX FSM next state: half-bit to mid start, then one sample per bit period
   always_comb begin
      rx_st_d   = rx_st_q;
      rx_cnt_d  = rx_tick ? rx_div_q : rx_cnt_q - 16'd1;
      rx_div_d  = rx_div_q;
      rx_bit_d  = rx_bit_q;
      rx_sh_d   = rx_sh_q;
      rx_perr_d = rx_perr_q;
      rx_push   = 1'b0;
      ferr_set  = 1'b0;
      case (rx_st_q)
         S_IDLE: begin
            rx_cnt_d = rx_cnt_q;
            if (rx_prev_q && !rx_s2_q) begin
               rx_st_d   = S_START;
               rx_div_d  = div_q;
               rx_cnt_d  = {1'b0, div_q[15:1]};
               rx_perr_d = 1'b0;
            end
         end
         S_START: if (rx_tick) begin
            rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
            rx_bit_d = 3'd0;
         end
         S_DATA: if (rx_tick) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = POST_DATA;
         end
         S_PAR: if (rx_tick) begin
            rx_perr_d = rx_s2_q ^ (^rx_sh_q);
            rx_st_d   = S_STOP;
         end
         S_STOP: if (rx_tick) begin
            rx_st_d  = S_IDLE;
            rx_push  = rx_s2_q;
            ferr_set = !rx_s2_q;
         end
         default: rx_st_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_io.sv
`timescale 1ns/1ps
// tb_uart_io: register table, directed frame sequences and randomized
// TX/RX traffic checked against a bit-level UART line model.
module tb_uart_io;
   localparam logic [7:0] BASE = 8'h20;

   logic       clk = 1'b0;
   logic       rst_n, w_en, r_en, rx, irq_flag_clr;
   logic [7:0] din, address;
   logic [7:0] dout;
   logic       tx, irq_flag;

   int checks = 0;
   int errors = 0;
   bit tx_log[$];

   always #5 clk = ~clk;

   // Record the serial output once per clock for frame decoding
   always @(negedge clk) tx_log.push_back(tx);

   uart_io #(.BASE_ADDR(BASE), .FIFO_AW(2), .DIV_RESET(16'd1665)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .address(address), .w_en(w_en),
      .r_en(r_en), .dout(dout), .rx(rx), .tx(tx), .irq_flag(irq_flag),
      .irq_flag_clr(irq_flag_clr));

   typedef struct {
      logic [7:0] off;
      logic       wr;
      logic [7:0] wdata;
      logic [7:0] exp;
      string      nm;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr_reg(input logic [7:0] off, input logic [7:0] d);
      address = BASE + off; din = d; w_en = 1'b1;
      @(negedge clk);
      w_en = 1'b0;
   endtask

   task automatic rd_reg(input logic [7:0] off, output logic [7:0] d);
      address = BASE + off; r_en = 1'b1;
      @(negedge clk);
      r_en = 1'b0;
      d = dout;
   endtask

   task automatic chk_reg(input string nm, input logic [7:0] off, input logic [7:0] exp);
      logic [7:0] v;
      rd_reg(off, v);
      chk(nm, v, exp);
   endtask

   task automatic set_div(input int div);
      wr_reg(8'd3, 8'(div));
      wr_reg(8'd4, 8'(div >> 8));
   endtask

   // Drive one serial frame: start, 8 data LSB first, stop level given
   task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
      for (int i = 0; i < 10; i++) begin
         rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
         repeat (div + 1) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic pulse_clr();
      irq_flag_clr = 1'b1;
      @(negedge clk);
      irq_flag_clr = 1'b0;
   endtask

   // Line model: frames must be contiguous 10-bit 8N1 frames, then idle line
   task automatic chk_tx_frames(input string nm, input int from, input int div,
                                input logic [7:0] exp_q[$]);
      int bp;
      int s0;
      logic idle_ok;
      bp = div + 1;
      s0 = -1;
      for (int i = from; i < tx_log.size(); i++)
         if (tx_log[i] == 1'b0) begin s0 = i; break; end
      chk({nm, "_start_found"}, (s0 >= 0 && s0 - from <= 8), 1);
      if (s0 < 0) return;
      for (int f = 0; f < exp_q.size(); f++) begin
         logic [11:0] got, want;
         int fs;
         fs = s0 + f * 10 * bp;
         want = {1'b1, 1'b0, 1'b1, exp_q[f], 1'b0};
         got[11] = (fs - 1 < tx_log.size()) ? tx_log[fs-1] : 1'bx;
         got[10] = (fs < tx_log.size()) ? tx_log[fs] : 1'bx;
         for (int b = 0; b < 10; b++) begin
            int idx;
            idx = fs + b * bp + bp / 2;
            got[b] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
         end
         chk($sformatf("%s_frame%0d", nm, f), got, want);
      end
      idle_ok = 1'b1;
      for (int i = s0 + exp_q.size() * 10 * bp; i < tx_log.size(); i++)
         if (tx_log[i] == 1'b0) idle_ok = 1'b0;
      chk({nm, "_idle_after"}, idle_ok, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] v, prev;
      logic [7:0] q[$];
      logic [7:0] exp_rx[$];
      logic [47:0] wgot, wwant;
      logic [9:0] fbits;
      int mark, s0, div, n;
      logic ovr;

      rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; rx = 1'b1; irq_flag_clr = 1'b0;
      din = 8'h00; address = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_dout", dout, 8'h00);
      chk("rst_tx", tx, 1'b1);
      chk("rst_irq", irq_flag, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Register map table
      vecs[0]  = '{8'd1,   1'b0, 8'h00, 8'h04, "status_rst"};
      vecs[1]  = '{8'd2,   1'b1, 8'hFF, 8'h03, "ctrl_mask"};
      vecs[2]  = '{8'd2,   1'b1, 8'h00, 8'h00, "ctrl_clear"};
      vecs[3]  = '{8'd3,   1'b0, 8'h00, 8'h81, "divlo_rst"};
      vecs[4]  = '{8'd4,   1'b0, 8'h00, 8'h06, "divhi_rst"};
      vecs[5]  = '{8'd3,   1'b1, 8'h5A, 8'h5A, "divlo_rw"};
      vecs[6]  = '{8'd4,   1'b1, 8'hC3, 8'hC3, "divhi_rw"};
      vecs[7]  = '{8'd5,   1'b1, 8'hFF, 8'h00, "unmapped_5"};
      vecs[8]  = '{8'hFF,  1'b1, 8'h12, 8'h00, "below_base"};
      vecs[9]  = '{8'h7F,  1'b0, 8'h00, 8'h00, "unmapped_7f"};
      vecs[10] = '{8'd0,   1'b0, 8'h00, 8'h00, "data_empty"};
      vecs[11] = '{8'd1,   1'b1, 8'h70, 8'h04, "status_w1c_idle"};
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) wr_reg(vecs[i].off, vecs[i].wdata);
         chk_reg(vecs[i].nm, vecs[i].off, vecs[i].exp);
      end

      // Write and read strobes together: write lands, dout holds
      prev = dout;
      address = BASE + 8'd2; din = 8'h01; w_en = 1'b1; r_en = 1'b1;
      @(negedge clk);
      w_en = 1'b0; r_en = 1'b0;
      chk("wr_rd_hold", dout, prev);
      chk_reg("wr_rd_write", 8'd2, 8'h01);
      wr_reg(8'd2, 8'h00);

      // TX 0xA5 at DIV=3: exact waveform, busy during frame
      set_div(3);
      mark = tx_log.size();
      wr_reg(8'd0, 8'hA5);
      for (int i = 0; i < 5; i++) begin
         repeat (5) @(negedge clk);
         chk_reg($sformatf("a5_busy%0d", i), 8'd1, 8'h08);
      end
      repeat (50) @(negedge clk);
      chk_reg("a5_done_status", 8'd1, 8'h04);
      s0 = -1;
      for (int i = mark; i < tx_log.size(); i++)
         if (tx_log[i] == 1'b0) begin s0 = i; break; end
      chk("a5_latency", (s0 >= 0 && s0 - mark <= 6), 1);
      fbits = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 48; k++) begin
         wwant[k] = (k < 40) ? fbits[k/4] : 1'b1;
         wgot[k]  = (s0 >= 0 && s0 + k < tx_log.size()) ? tx_log[s0+k] : 1'bx;
      end
      chk("a5_wave", wgot, wwant);

      // RX 0x3C with rx_ie
      wr_reg(8'd2, 8'h01);
      send_rx(8'h3C, 3, 1'b1);
      repeat (4) @(negedge clk);
      chk_reg("rx3c_status", 8'd1, 8'h05);
      chk("rx3c_irq", irq_flag, 1'b1);
      chk_reg("rx3c_data", 8'd0, 8'h3C);
      chk_reg("rx3c_empty", 8'd1, 8'h04);
      pulse_clr();
      chk("rx3c_irq_clr", irq_flag, 1'b0);
      wr_reg(8'd2, 8'h00);

      // Framing error then a one-clock glitch
      send_rx(8'h55, 3, 1'b0);
      repeat (8) @(negedge clk);
      chk_reg("ferr_status", 8'd1, 8'h24);
      wr_reg(8'd1, 8'h20);
      chk_reg("ferr_cleared", 8'd1, 8'h04);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk_reg("glitch_status", 8'd1, 8'h04);

      // Five random RX bytes, no reads: four kept, overrun set
      div = $urandom_range(2, 6);
      set_div(div);
      exp_rx.delete();
      ovr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = 8'($urandom);
         if (exp_rx.size() < 4) exp_rx.push_back(v); else ovr = 1'b1;
         send_rx(v, div, 1'b1);
      end
      repeat (4) @(negedge clk);
      chk_reg("ovr_status", 8'd1, {3'b000, ovr, 4'b0101});
      for (int i = 0; i < 4; i++) chk_reg($sformatf("ovr_data%0d", i), 8'd0, exp_rx[i]);
      chk_reg("ovr_drained", 8'd0, 8'h00);
      wr_reg(8'd1, 8'h10);
      chk_reg("ovr_cleared", 8'd1, 8'h04);

      // Randomized RX traffic within FIFO capacity
      for (int it = 0; it < 3; it++) begin
         div = $urandom_range(2, 6);
         set_div(div);
         n = $urandom_range(1, 4);
         exp_rx.delete();
         for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            exp_rx.push_back(v);
            send_rx(v, div, 1'b1);
         end
         repeat (4) @(negedge clk);
         chk_reg($sformatf("rrx%0d_status", it), 8'd1, 8'h05);
         while (exp_rx.size() > 0) chk_reg($sformatf("rrx%0d_data", it), 8'd0, exp_rx.pop_front());
         chk_reg($sformatf("rrx%0d_empty", it), 8'd1, 8'h04);
      end

      // Randomized TX traffic with small write gaps
      for (int it = 0; it < 3; it++) begin
         div = $urandom_range(1, 5);
         set_div(div);
         n = $urandom_range(1, 4);
         q.delete();
         mark = tx_log.size();
         for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            q.push_back(v);
            wr_reg(8'd0, v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         repeat (n * 10 * (div + 1) + 20) @(negedge clk);
         chk_tx_frames($sformatf("rtx%0d", it), mark, div, q);
      end

      // Six back-to-back writes: five sent contiguously, sixth dropped; txe irq
      div = $urandom_range(1, 4);
      set_div(div);
      wr_reg(8'd2, 8'h02);
      q.delete();
      mark = tx_log.size();
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom);
         if (i < 5) q.push_back(v);
         address = BASE; din = v; w_en = 1'b1;
         @(negedge clk);
      end
      w_en = 1'b0;
      repeat (5 * 10 * (div + 1) + 40) @(negedge clk);
      chk_tx_frames("tx6", mark, div, q);
      chk("tx6_irq", irq_flag, 1'b1);
      pulse_clr();
      chk("tx6_irq_clr", irq_flag, 1'b0);
      wr_reg(8'd2, 8'h00);
      chk_reg("tx6_status", 8'd1, 8'h04);

      // Reset in the middle of a frame forces the line idle at once
      set_div(3);
      wr_reg(8'd0, 8'h00);
      repeat (8) @(negedge clk);
      chk("midrst_tx_low", tx, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_tx_high", tx, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_reg("midrst_status", 8'd1, 8'h04);
      chk_reg("midrst_divlo", 8'd3, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
